// File: rtl/nn_config_loader_if.sv
// Byte stream carrying configuration frames into the NN config loader.
// The source drives valid/data; the loader answers with ready.
interface nn_config_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    // Frame source side
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Loader side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/nn_config_loader.sv
// Front-end of the CORDIC NN accelerator. Receives a 10-byte configuration
// frame (header 0xA5, layer count, five neuron counts, packed activation
// selects, XOR checksum), validates it, then publishes the configuration and
// a one-cycle start pulse. The configuration is held for the whole run and
// no further bytes are accepted until the accelerator signals acc_done.
module nn_config_loader (
    input  logic              clk,
    input  logic              rst_n,
    nn_config_loader_if.slave cfg_stream,
    input  logic              acc_done,
    output logic              start,
    output logic [5:0]        no_layers,
    output logic [5:0]        nl1,
    output logic [5:0]        nl2,
    output logic [5:0]        nl3,
    output logic [5:0]        nl4,
    output logic [5:0]        nl5,
    output logic [1:0]        afl1,
    output logic [1:0]        afl2,
    output logic [1:0]        afl3,
    output logic [1:0]        afl4,
    output logic [1:0]        afl5,
    output logic              busy,
    output logic              cfg_err,
    output logic [1:0]        err_code
);

    localparam logic [7:0]  Header     = 8'hA5;
    // Bytes b1..b9 live in the shadow buffer at indices 0..8.
    localparam int unsigned ShadowLen  = 9;
    localparam logic [3:0]  LastIdx    = 4'd8;
    localparam logic [5:0]  MaxLayers  = 6'd5;

    typedef enum logic [2:0] {
        StHunt,
        StRecv,
        StCheck,
        StFire,
        StRun
    } state_e;

    typedef enum logic [1:0] {
        ErrNone     = 2'b00,
        ErrChecksum = 2'b01,
        ErrLayers   = 2'b10,
        ErrField    = 2'b11
    } err_e;

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] shadow_q [ShadowLen];
    logic       accept;

    // Decoded view of the shadow buffer
    logic [7:0] cs_calc;
    logic [5:0] lay_field;
    logic       lay_bad;
    logic       rsvd_set;
    logic [4:0] nl_used;
    logic [4:0] nl_zero;
    err_e       chk_code;
    logic       chk_pass;

    // Output registers
    logic [5:0] no_layers_q;
    logic [5:0] nl1_q, nl2_q, nl3_q, nl4_q, nl5_q;
    logic [1:0] afl1_q, afl2_q, afl3_q, afl4_q, afl5_q;
    logic       cfg_err_q;
    logic [1:0] err_code_q;

    // Ready, start and busy are pure decodes of the state register, so no
    // input ever reaches an output combinationally.
    assign cfg_stream.in_ready = (state_q == StHunt) || (state_q == StRecv);
    assign accept              = cfg_stream.in_valid && cfg_stream.in_ready;
    assign start               = (state_q == StFire);
    assign busy                = (state_q == StFire) || (state_q == StRun);

    assign no_layers = no_layers_q;
    assign nl1       = nl1_q;
    assign nl2       = nl2_q;
    assign nl3       = nl3_q;
    assign nl4       = nl4_q;
    assign nl5       = nl5_q;
    assign afl1      = afl1_q;
    assign afl2      = afl2_q;
    assign afl3      = afl3_q;
    assign afl4      = afl4_q;
    assign afl5      = afl5_q;
    assign cfg_err   = cfg_err_q;
    assign err_code  = err_code_q;

    // Running XOR over b1..b8 for comparison against the received b9
    always_comb begin
        cs_calc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cs_calc = cs_calc ^ shadow_q[i];
        end
    end

    // Field decode: layer count range, reserved bits, empty active layers
    always_comb begin
        lay_field = shadow_q[0][5:0];
        lay_bad   = (lay_field == 6'd0) || (lay_field > MaxLayers);

        rsvd_set  = (|shadow_q[0][7:6]) | (|shadow_q[1][7:6]) | (|shadow_q[2][7:6]) |
                    (|shadow_q[3][7:6]) | (|shadow_q[4][7:6]) | (|shadow_q[5][7:6]) |
                    (|shadow_q[7][7:2]);

        // Layer k only has to be non-empty when it is within the layer count.
        nl_used[0] = (lay_field >= 6'd1);
        nl_used[1] = (lay_field >= 6'd2);
        nl_used[2] = (lay_field >= 6'd3);
        nl_used[3] = (lay_field >= 6'd4);
        nl_used[4] = (lay_field >= 6'd5);

        nl_zero[0] = (shadow_q[1][5:0] == 6'd0);
        nl_zero[1] = (shadow_q[2][5:0] == 6'd0);
        nl_zero[2] = (shadow_q[3][5:0] == 6'd0);
        nl_zero[3] = (shadow_q[4][5:0] == 6'd0);
        nl_zero[4] = (shadow_q[5][5:0] == 6'd0);
    end

    // Error classification, first match wins
    always_comb begin
        chk_code = ErrNone;
        if (cs_calc != shadow_q[8]) begin
            chk_code = ErrChecksum;
        end else if (lay_bad) begin
            chk_code = ErrLayers;
        end else if (rsvd_set || (|(nl_zero & nl_used))) begin
            chk_code = ErrField;
        end
        chk_pass = (chk_code == ErrNone);
    end

    // Frame sequencing: hunt for header, collect payload, validate, run
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StHunt: begin
                // Non-header bytes are swallowed here to resynchronise.
                if (accept && (cfg_stream.in_data == Header)) begin
                    state_d = StRecv;
                    idx_d   = 4'd0;
                end
            end
            StRecv: begin
                // 0xA5 inside a frame is plain data.
                if (accept) begin
                    if (idx_q == LastIdx) begin
                        state_d = StCheck;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StCheck: begin
                state_d = chk_pass ? StFire : StHunt;
            end
            StFire: begin
                state_d = StRun;
            end
            StRun: begin
                if (acc_done) begin
                    state_d = StHunt;
                end
            end
            default: begin
                state_d = StHunt;
            end
        endcase
    end

    // State and byte index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHunt;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Shadow capture of b1..b9; the live configuration is never touched here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ShadowLen; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else if ((state_q == StRecv) && accept) begin
            shadow_q[idx_q] <= cfg_stream.in_data;
        end
    end

    // Publish a validated frame on the edge that enters FIRE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            no_layers_q <= 6'd0;
            nl1_q       <= 6'd0;
            nl2_q       <= 6'd0;
            nl3_q       <= 6'd0;
            nl4_q       <= 6'd0;
            nl5_q       <= 6'd0;
            afl1_q      <= 2'd0;
            afl2_q      <= 2'd0;
            afl3_q      <= 2'd0;
            afl4_q      <= 2'd0;
            afl5_q      <= 2'd0;
        end else if ((state_q == StCheck) && chk_pass) begin
            no_layers_q <= shadow_q[0][5:0];
            nl1_q       <= shadow_q[1][5:0];
            nl2_q       <= shadow_q[2][5:0];
            nl3_q       <= shadow_q[3][5:0];
            nl4_q       <= shadow_q[4][5:0];
            nl5_q       <= shadow_q[5][5:0];
            afl1_q      <= shadow_q[6][1:0];
            afl2_q      <= shadow_q[6][3:2];
            afl3_q      <= shadow_q[6][5:4];
            afl4_q      <= shadow_q[6][7:6];
            afl5_q      <= shadow_q[7][1:0];
        end
    end

    // Sticky error flag: set by a rejected frame, cleared by the next good one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q  <= 1'b0;
            err_code_q <= ErrNone;
        end else if (state_q == StCheck) begin
            cfg_err_q  <= !chk_pass;
            err_code_q <= chk_code;
        end
    end

endmodule

// File: tb/tb_nn_config_loader.sv
// Directed bench for nn_config_loader: a table of frames with hand-computed
// outcomes, plus sequences for back-pressure during a run, a stray acc_done
// and a reset in the middle of a frame.
module tb_nn_config_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       acc_done;
    logic       start;
    logic [5:0] no_layers;
    logic [5:0] nl1, nl2, nl3, nl4, nl5;
    logic [1:0] afl1, afl2, afl3, afl4, afl5;
    logic       busy;
    logic       cfg_err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nn_config_loader_if stream_if ();

    nn_config_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_stream (stream_if),
        .acc_done   (acc_done),
        .start      (start),
        .no_layers  (no_layers),
        .nl1        (nl1),
        .nl2        (nl2),
        .nl3        (nl3),
        .nl4        (nl4),
        .nl5        (nl5),
        .afl1       (afl1),
        .afl2       (afl2),
        .afl3       (afl3),
        .afl4       (afl4),
        .afl5       (afl5),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .err_code   (err_code)
    );

    // b[9] is header byte b0 (first sent); n[4] is nl1; a[4] is afl1.
    typedef struct packed {
        logic            garbage;
        logic [9:0][7:0] b;
        logic [1:0]      err;
        logic [5:0]      nlay;
        logic [4:0][5:0] n;
        logic [4:0][1:0] a;
    } vec_t;

    localparam int NumVec = 11;
    vec_t vecs [NumVec];

    // Expected configuration currently on the outputs
    logic [5:0]      e_nlay = 6'd0;
    logic [4:0][5:0] e_n    = '0;
    logic [4:0][1:0] e_a    = '0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cfg(input string tag);
        check({tag, ".no_layers"}, 8'(no_layers), 8'(e_nlay));
        check({tag, ".nl1"}, 8'(nl1), 8'(e_n[4]));
        check({tag, ".nl2"}, 8'(nl2), 8'(e_n[3]));
        check({tag, ".nl3"}, 8'(nl3), 8'(e_n[2]));
        check({tag, ".nl4"}, 8'(nl4), 8'(e_n[1]));
        check({tag, ".nl5"}, 8'(nl5), 8'(e_n[0]));
        check({tag, ".afl1"}, 8'(afl1), 8'(e_a[4]));
        check({tag, ".afl2"}, 8'(afl2), 8'(e_a[3]));
        check({tag, ".afl3"}, 8'(afl3), 8'(e_a[2]));
        check({tag, ".afl4"}, 8'(afl4), 8'(e_a[1]));
        check({tag, ".afl5"}, 8'(afl5), 8'(e_a[0]));
    endtask

    // One transfer: present the byte, wait (bounded) for ready, complete on an edge
    task automatic send_byte(input logic [7:0] data);
        int n = 0;
        @(negedge clk);
        stream_if.in_valid = 1'b1;
        stream_if.in_data  = data;
        while (!stream_if.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for byte %0h", data);
        end
        @(posedge clk);
        #1;
        stream_if.in_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_byte(v.b[9-i]);
        end
    endtask

    // Called right after b9 was accepted at edge T
    task automatic expect_result(input vec_t v, input string tag);
        @(negedge clk);
        check({tag, ".check_in_ready"}, 8'(stream_if.in_ready), 8'd0);
        check({tag, ".check_start"}, 8'(start), 8'd0);
        @(negedge clk);
        if (v.err == 2'b00) begin
            e_nlay = v.nlay;
            e_n    = v.n;
            e_a    = v.a;
            check({tag, ".fire_start"}, 8'(start), 8'd1);
            check({tag, ".fire_busy"}, 8'(busy), 8'd1);
            check({tag, ".fire_cfg_err"}, 8'(cfg_err), 8'd0);
            check({tag, ".fire_err_code"}, 8'(err_code), 8'd0);
            check_cfg({tag, ".fire"});
            @(negedge clk);
            check({tag, ".run_start"}, 8'(start), 8'd0);
            check({tag, ".run_busy"}, 8'(busy), 8'd1);
            check({tag, ".run_in_ready"}, 8'(stream_if.in_ready), 8'd0);
            check_cfg({tag, ".run"});
            acc_done = 1'b1;
            @(negedge clk);
            acc_done = 1'b0;
            check({tag, ".done_busy"}, 8'(busy), 8'd0);
            check({tag, ".done_in_ready"}, 8'(stream_if.in_ready), 8'd1);
            check({tag, ".done_start"}, 8'(start), 8'd0);
        end else begin
            check({tag, ".rej_start"}, 8'(start), 8'd0);
            check({tag, ".rej_busy"}, 8'(busy), 8'd0);
            check({tag, ".rej_cfg_err"}, 8'(cfg_err), 8'd1);
            check({tag, ".rej_err_code"}, 8'(err_code), 8'(v.err));
            check({tag, ".rej_in_ready"}, 8'(stream_if.in_ready), 8'd1);
            check_cfg({tag, ".rej_hold"});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        acc_done           = 1'b0;
        stream_if.in_valid = 1'b0;
        stream_if.in_data  = 8'h00;

        //           garbage  b0..b9                                                 err    nlay  nl1..nl5                    afl1..afl5
        vecs[0]  = '{1'b0, {8'hA5,8'h03,8'h04,8'h02,8'h03,8'h02,8'h01,8'h00,8'h00,8'h05},
                     2'd0, 6'd3,  {6'd4,6'd2,6'd3,6'd2,6'd1},  {2'd0,2'd0,2'd0,2'd0,2'd0}};
        vecs[1]  = '{1'b0, {8'hA5,8'h02,8'h05,8'h06,8'h00,8'h00,8'h00,8'h00,8'h00,8'hFF},
                     2'd1, 6'd0,  '0, '0};
        vecs[2]  = '{1'b1, {8'hA5,8'h05,8'h01,8'h02,8'h03,8'h04,8'h05,8'hE4,8'h02,8'hE2},
                     2'd0, 6'd5,  {6'd1,6'd2,6'd3,6'd4,6'd5},  {2'd0,2'd1,2'd2,2'd3,2'd2}};
        vecs[3]  = '{1'b0, {8'hA5,8'h06,8'h01,8'h01,8'h01,8'h01,8'h01,8'h00,8'h00,8'h07},
                     2'd2, 6'd0,  '0, '0};
        vecs[4]  = '{1'b0, {8'hA5,8'h02,8'h07,8'h00,8'h09,8'h00,8'h00,8'h00,8'h00,8'h0C},
                     2'd3, 6'd0,  '0, '0};
        vecs[5]  = '{1'b0, {8'hA5,8'h43,8'h01,8'h01,8'h01,8'h00,8'h00,8'h00,8'h00,8'h42},
                     2'd3, 6'd0,  '0, '0};
        vecs[6]  = '{1'b0, {8'hA5,8'h01,8'h3F,8'h00,8'h00,8'h00,8'h00,8'h00,8'h04,8'h3A},
                     2'd3, 6'd0,  '0, '0};
        vecs[7]  = '{1'b0, {8'hA5,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h01},
                     2'd2, 6'd0,  '0, '0};
        vecs[8]  = '{1'b0, {8'hA5,8'h07,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                     2'd1, 6'd0,  '0, '0};
        vecs[9]  = '{1'b0, {8'hA5,8'h01,8'h3F,8'h00,8'h00,8'h00,8'h00,8'h1B,8'h03,8'h26},
                     2'd0, 6'd1,  {6'd63,6'd0,6'd0,6'd0,6'd0}, {2'd3,2'd2,2'd1,2'd0,2'd3}};
        vecs[10] = '{1'b0, {8'hA5,8'h02,8'h01,8'h02,8'h00,8'h00,8'h00,8'hA5,8'h00,8'hA4},
                     2'd0, 6'd2,  {6'd1,6'd2,6'd0,6'd0,6'd0},  {2'd1,2'd1,2'd2,2'd2,2'd0}};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.in_ready", 8'(stream_if.in_ready), 8'd1);
        check("rst.start", 8'(start), 8'd0);
        check("rst.busy", 8'(busy), 8'd0);
        check("rst.cfg_err", 8'(cfg_err), 8'd0);
        check("rst.err_code", 8'(err_code), 8'd0);
        check_cfg("rst");
        rst_n = 1'b1;

        // Table of frames
        for (int k = 0; k < NumVec; k++) begin
            if (vecs[k].garbage) begin
                send_byte(8'h00);
                send_byte(8'hFF);
                send_byte(8'h12);
                @(negedge clk);
                check($sformatf("v%0d.garbage_in_ready", k), 8'(stream_if.in_ready), 8'd1);
                check($sformatf("v%0d.garbage_start", k), 8'(start), 8'd0);
            end
            send_frame(vecs[k], 0, 9);
            expect_result(vecs[k], $sformatf("v%0d", k));
        end

        // Header held on the stream during a run: must wait for acc_done
        send_frame(vecs[0], 0, 9);
        @(negedge clk);
        @(negedge clk);
        check("hold.start", 8'(start), 8'd1);
        stream_if.in_valid = 1'b1;
        stream_if.in_data  = 8'hA5;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("hold.in_ready%0d", c), 8'(stream_if.in_ready), 8'd0);
            check($sformatf("hold.busy%0d", c), 8'(busy), 8'd1);
        end
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        check("hold.after_done_in_ready", 8'(stream_if.in_ready), 8'd1);
        check("hold.after_done_busy", 8'(busy), 8'd0);
        @(posedge clk);
        #1;
        stream_if.in_valid = 1'b0;
        // Header went in at D+1; the rest of the frame must line up behind it.
        send_frame(vecs[2], 1, 9);
        expect_result(vecs[2], "hold_next");

        // Stray acc_done while hunting
        @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        check("stray.busy", 8'(busy), 8'd0);
        check("stray.start", 8'(start), 8'd0);
        check("stray.in_ready", 8'(stream_if.in_ready), 8'd1);
        check("stray.cfg_err", 8'(cfg_err), 8'd0);
        check_cfg("stray");

        // Reset after b5 of a partial frame
        send_frame(vecs[9], 0, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        e_nlay = 6'd0;
        e_n    = '0;
        e_a    = '0;
        check("midrst.in_ready", 8'(stream_if.in_ready), 8'd1);
        check("midrst.start", 8'(start), 8'd0);
        check("midrst.busy", 8'(busy), 8'd0);
        check("midrst.cfg_err", 8'(cfg_err), 8'd0);
        check("midrst.err_code", 8'(err_code), 8'd0);
        check_cfg("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(vecs[0], 0, 9);
        expect_result(vecs[0], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
